// File: rtl/time_entry_pkg.sv
// Shared types, constants and helpers for the keypad time-entry controller.
package time_entry_pkg;

    // Each field is two packed BCD digits: tens in [7:4], ones in [3:0].
    localparam int BCD_W = 8;
    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_DONE
    } state_t;

    // Upper limits for up to eight fields: field 0 (hours) tops out at 23,
    // every later field (minutes, seconds, ...) at 59.
    localparam logic [8*BCD_W-1:0] DEFAULT_FIELD_MAX = 64'h5959_5959_5959_5923;

    // BCD a <= b, comparing tens first and ones only when the tens match.
    function automatic logic bcd_le(input bcd_t a, input bcd_t b);
        if (a[7:4] != b[7:4]) return a[7:4] < b[7:4];
        return a[3:0] <= b[3:0];
    endfunction

endpackage

// File: rtl/time_entry_ctrl_if.sv
// Keypad-side and core-side signals of the time-entry controller.
interface time_entry_ctrl_if #(
    parameter int NUM_FIELDS = 3
);
    logic                    en;
    logic [9:0]              keypad;
    logic                    sharp;
    logic                    star;
    logic [8*NUM_FIELDS-1:0] disp_bcd;
    logic [8*NUM_FIELDS-1:0] set_bcd;
    logic [NUM_FIELDS-1:0]   field_sel;
    logic                    busy;
    logic                    complete;
    logic                    err;
    logic                    timeout;

    // Keypad scanner / host side.
    modport master (
        output en, keypad, sharp, star,
        input  disp_bcd, set_bcd, field_sel, busy, complete, err, timeout
    );

    // Controller side.
    modport slave (
        input  en, keypad, sharp, star,
        output disp_bcd, set_bcd, field_sel, busy, complete, err, timeout
    );
endinterface

// File: rtl/key_event.sv
// Turns raw key levels into single-cycle key events: a vector with exactly
// one key down, following a cycle with no key down at all.
module key_event (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keypad,
    input  logic       sharp,
    input  logic       star,
    output logic       evt_digit,
    output logic [3:0] evt_val,
    output logic       evt_sharp,
    output logic       evt_star
);
    logic [11:0] vec;
    logic [11:0] prev_q;
    logic        fire;

    assign vec  = {star, sharp, keypad};
    assign fire = $onehot(vec) && (prev_q == '0);

    // Remember last cycle's keys so a held key fires only once.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst) prev_q <= '0;
        else      prev_q <= vec;
    end

    // One-hot digit key to its decimal value.
    always_comb begin
        // NOTE: default first so no path leaves evt_val unassigned (no latch).
        evt_val = '0;
        for (int d = 0; d < 10; d++) begin
            if (keypad[d]) evt_val = 4'(d);
        end
    end

    assign evt_digit = fire && (keypad != '0);
    assign evt_sharp = fire && sharp;
    assign evt_star  = fire && star;

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: edits NUM_FIELDS two-digit BCD fields,
// range-checks each on '#', and publishes all of them only on full commit.
module time_entry_ctrl
    import time_entry_pkg::*;
#(
    parameter int                      NUM_FIELDS  = 3,
    parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX   = DEFAULT_FIELD_MAX[8*NUM_FIELDS-1:0],
    parameter int unsigned             TIMEOUT_CYC = 50_000_000
) (
    input logic              clk,
    input logic              rst,
    time_entry_ctrl_if.slave bus
);
    localparam int               IDX_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_FIELDS - 1);
    localparam bcd_t [NUM_FIELDS-1:0] FMAX  = FIELD_MAX;
    localparam logic [31:0]      TIMER_LAST = TIMEOUT_CYC - 1;

    state_t                  state, state_next;
    logic                    en_q;
    logic [IDX_W-1:0]        idx;
    logic [1:0]              digit_cnt;
    logic [31:0]             idle_cnt;
    bcd_t [NUM_FIELDS-1:0]   work;
    bcd_t [NUM_FIELDS-1:0]   set_q;
    logic                    err_q, complete_q, timeout_q;

    logic                    evt_digit, evt_sharp, evt_star, evt_any;
    logic [3:0]              evt_val;
    logic                    field_ok, timer_hit;
    logic                    do_load, do_shift, do_clear, do_back;
    logic                    do_next, do_fail, do_commit, do_timeout;

    key_event u_key_event (
        .clk       (clk),
        .rst       (rst),
        .keypad    (bus.keypad),
        .sharp     (bus.sharp),
        .star      (bus.star),
        .evt_digit (evt_digit),
        .evt_val   (evt_val),
        .evt_sharp (evt_sharp),
        .evt_star  (evt_star)
    );

    assign evt_any = evt_digit | evt_sharp | evt_star;
    // A field with no digits typed keeps its loaded value and always passes.
    assign field_ok  = (digit_cnt == 2'd0) || bcd_le(work[idx], FMAX[idx]);
    assign timer_hit = (TIMEOUT_CYC != 0) && (idle_cnt == TIMER_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next state and one-cycle action strobes for the datapath.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_clear   = 1'b0;
        do_back    = 1'b0;
        do_next    = 1'b0;
        do_fail    = 1'b0;
        do_commit  = 1'b0;
        do_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.en && !en_q) begin
                    do_load    = 1'b1;
                    state_next = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (!bus.en) begin
                    state_next = S_IDLE;                 // silent abort
                end else if (evt_digit) begin
                    do_shift = 1'b1;
                end else if (evt_sharp) begin
                    state_next = S_CHECK;
                end else if (evt_star) begin
                    if (digit_cnt != 2'd0) do_clear = 1'b1;
                    else if (idx != '0)    do_back  = 1'b1;
                end else if (timer_hit) begin
                    do_timeout = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_CHECK: begin
                if (!field_ok) begin
                    do_fail    = 1'b1;
                    state_next = S_ENTRY;
                end else if (idx == LAST_IDX) begin
                    state_next = S_DONE;
                end else begin
                    do_next    = 1'b1;
                    state_next = S_ENTRY;
                end
            end
            S_DONE: begin
                do_commit  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Working/committed fields, field index, digit and idle counters, pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the field arrays are a few flops, so they are reset like any other register.
            en_q       <= 1'b0;
            idx        <= '0;
            digit_cnt  <= '0;
            idle_cnt   <= '0;
            work       <= '0;
            set_q      <= '0;
            err_q      <= 1'b0;
            complete_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            en_q       <= bus.en;
            err_q      <= do_fail;
            complete_q <= do_commit;
            timeout_q  <= do_timeout;
            if (state == S_ENTRY) idle_cnt <= evt_any ? '0 : idle_cnt + 32'd1;
            if (do_load) begin
                work      <= set_q;
                idx       <= '0;
                digit_cnt <= '0;
                idle_cnt  <= '0;
            end
            if (do_shift) begin
                work[idx] <= {work[idx][3:0], evt_val};
                if (digit_cnt != 2'd2) digit_cnt <= digit_cnt + 2'd1;
            end
            if (do_clear || do_fail) begin
                work[idx] <= '0;
                digit_cnt <= '0;
            end
            if (do_back) idx <= idx - 1'b1;
            if (do_next) begin
                idx       <= idx + 1'b1;
                digit_cnt <= '0;
            end
            if (do_commit) set_q <= work;
        end
    end

    assign bus.busy      = (state == S_ENTRY) || (state == S_CHECK);
    assign bus.disp_bcd  = bus.busy ? work : set_q;
    assign bus.set_bcd   = set_q;
    assign bus.field_sel = (state == S_ENTRY) ? (NUM_FIELDS'(1) << idx) : '0;
    assign bus.complete  = complete_q;
    assign bus.err       = err_q;
    assign bus.timeout   = timeout_q;

endmodule
